// File: rtl/byte_frame_assembler_if.sv
// byte_frame_assembler_if: byte-pipe input and frame get-method bundle for the frame assembler
interface byte_frame_assembler_if #(
  parameter int MAX_BYTES = 8,
  parameter int ERR_W     = 16
);
  localparam int LEN_W = $clog2(MAX_BYTES + 1);
  logic [7:0]             in_data;
  logic                   in_rdy;
  logic                   in_en;
  logic                   en_frame;
  logic                   rdy_frame;
  logic [8*MAX_BYTES-1:0] frame;
  logic [LEN_W-1:0]       frame_len;
  logic                   frame_err;
  logic [ERR_W-1:0]       err_count;
  modport master (
    input  in_data, in_rdy, en_frame,
    output in_en, rdy_frame, frame, frame_len, frame_err, err_count
  );
  modport slave (
    output in_data, in_rdy, en_frame,
    input  in_en, rdy_frame, frame, frame_len, frame_err, err_count
  );
endinterface

// File: rtl/byte_frame_assembler.sv
// byte_frame_assembler: parses [LEN][payload][CSUM] byte frames into a little-endian word with checksum status
module byte_frame_assembler #(
  parameter int MAX_BYTES = 8,
  parameter int ERR_W     = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  byte_frame_assembler_if.master bus
);
  localparam int LEN_W = $clog2(MAX_BYTES + 1);
  localparam logic [7:0] MAX8 = 8'(MAX_BYTES);
  typedef enum logic [1:0] {S_LEN, S_PAY, S_CSUM, S_HOLD} state_t;
  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d, idx_q, idx_d, frame_len_q, frame_len_d;
  logic [7:0]             sum_q, sum_d;
  logic [8*MAX_BYTES-1:0] frame_q, frame_d;
  logic                   frame_err_q, frame_err_d, rdy_q, rdy_d, err_inc;
  logic [ERR_W-1:0]       err_q, err_d;
  logic                   in_en;
  assign in_en         = rst_n & bus.in_rdy & (state_q != S_HOLD);
  assign bus.in_en     = in_en;
  assign bus.rdy_frame = rdy_q;
  assign bus.frame     = frame_q;
  assign bus.frame_len = frame_len_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_count = err_q;
  // next-state and datapath: one byte per accepted cycle, hold until the frame is taken
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    frame_d     = frame_q;
    frame_len_d = frame_len_q;
    frame_err_d = frame_err_q;
    rdy_d       = rdy_q;
    err_inc     = 1'b0;
    case (state_q)
      S_LEN: if (in_en) begin
        if (bus.in_data == 8'd0 || bus.in_data > MAX8) err_inc = 1'b1;
        else begin
          len_d   = bus.in_data[LEN_W-1:0];
          idx_d   = '0;
          sum_d   = '0;
          frame_d = '0;
          state_d = S_PAY;
        end
      end
      S_PAY: if (in_en) begin
        frame_d[8*idx_q +: 8] = bus.in_data;
        sum_d   = sum_q + bus.in_data;
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == len_q - 1'b1) ? S_CSUM : S_PAY;
      end
      S_CSUM: if (in_en) begin
        frame_len_d = len_q;
        frame_err_d = bus.in_data != sum_q;
        err_inc     = bus.in_data != sum_q;
        rdy_d       = 1'b1;
        state_d     = S_HOLD;
      end
      default: if (bus.en_frame) begin
        rdy_d   = 1'b0;
        state_d = S_LEN;
      end
    endcase
    err_d = (err_inc && err_q != '1) ? err_q + 1'b1 : err_q;
  end
  // state and registered outputs; reset discards any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LEN;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      frame_q     <= '0;
      frame_len_q <= '0;
      frame_err_q <= 1'b0;
      rdy_q       <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      frame_q     <= frame_d;
      frame_len_q <= frame_len_d;
      frame_err_q <= frame_err_d;
      rdy_q       <= rdy_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_byte_frame_assembler.sv
// tb_byte_frame_assembler: directed checks of frame parsing, checksum, errors, backpressure and reset
module tb_byte_frame_assembler;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  byte_frame_assembler_if #(.MAX_BYTES(8), .ERR_W(16)) bus ();
  byte_frame_assembler #(.MAX_BYTES(8), .ERR_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send_gap(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.in_rdy = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_data = b;
    bus.in_rdy  = 1'b1;
    #1;
    for (int n = 0; n < 20 && !bus.in_en; n++) begin
      @(negedge clk);
      #1;
    end
    chk("in_en_wait", 64'(bus.in_en), 64'd1);
    @(posedge clk);
  endtask
  task automatic send(input logic [7:0] b);
    send_gap(b, 0);
  endtask
  task automatic done_frame(input string tag, input logic [63:0] f, input logic [3:0] l,
                            input logic e, input logic [15:0] ec);
    @(negedge clk);
    bus.in_rdy = 1'b0;
    chk({tag, "_rdy"}, 64'(bus.rdy_frame), 64'd1);
    chk({tag, "_frame"}, bus.frame, f);
    chk({tag, "_len"}, 64'(bus.frame_len), 64'(l));
    chk({tag, "_err"}, 64'(bus.frame_err), 64'(e));
    chk({tag, "_errcnt"}, 64'(bus.err_count), 64'(ec));
  endtask
  task automatic take();
    @(negedge clk);
    bus.en_frame = 1'b1;
    @(negedge clk);
    bus.en_frame = 1'b0;
    chk("take_rdy", 64'(bus.rdy_frame), 64'd0);
  endtask
  initial begin
    rst_n        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_rdy   = 1'b1;
    bus.en_frame = 1'b0;
    #1;
    chk("rst_in_en", 64'(bus.in_en), 64'd0);
    chk("rst_rdy", 64'(bus.rdy_frame), 64'd0);
    chk("rst_frame", bus.frame, 64'd0);
    chk("rst_errcnt", 64'(bus.err_count), 64'd0);
    @(negedge clk);
    bus.in_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    #1;
    chk("t1_rdy_before_csum", 64'(bus.rdy_frame), 64'd0);
    send(8'h66);
    done_frame("t1", 64'h332211, 4'd3, 1'b0, 16'd0);
    take();
    send(8'h02); send(8'hFF); send(8'h02); send(8'h01);
    done_frame("t2_wrap", 64'h02FF, 4'd2, 1'b0, 16'd0);
    take();
    send(8'h01); send(8'hAA); send(8'h00);
    done_frame("t3_bad", 64'hAA, 4'd1, 1'b1, 16'd1);
    take();
    send(8'h01); send(8'h55); send(8'h55);
    done_frame("t3_good", 64'h55, 4'd1, 1'b0, 16'd1);
    bus.in_data = 8'h01;
    bus.in_rdy  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_in_en_hold", 64'(bus.in_en), 64'd0);
      chk("t5_frame_stable", bus.frame, 64'h55);
    end
    bus.en_frame = 1'b1;
    #1;
    chk("t5_in_en_same_cycle", 64'(bus.in_en), 64'd0);
    @(negedge clk);
    bus.en_frame = 1'b0;
    chk("t5_in_en_next", 64'(bus.in_en), 64'd1);
    @(posedge clk);
    send(8'hC3); send(8'hC3);
    done_frame("t5_next", 64'hC3, 4'd1, 1'b0, 16'd1);
    take();
    send(8'h00); send(8'h09); send(8'h01); send(8'h7E); send(8'h7E);
    done_frame("t4_badlen", 64'h7E, 4'd1, 1'b0, 16'd3);
    take();
    send_gap(8'h08, $urandom_range(0, 3));
    for (int i = 1; i <= 8; i++) send_gap(8'(i), $urandom_range(0, 3));
    send_gap(8'h24, $urandom_range(0, 3));
    done_frame("t6_full", 64'h0807060504030201, 4'd8, 1'b0, 16'd3);
    take();
    send(8'h03); send(8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t7_in_en", 64'(bus.in_en), 64'd0);
    chk("t7_rdy", 64'(bus.rdy_frame), 64'd0);
    chk("t7_frame", bus.frame, 64'd0);
    chk("t7_len", 64'(bus.frame_len), 64'd0);
    chk("t7_err", 64'(bus.frame_err), 64'd0);
    chk("t7_errcnt", 64'(bus.err_count), 64'd0);
    @(negedge clk);
    bus.in_rdy = 1'b0;
    rst_n = 1'b1;
    send(8'h01); send(8'h42); send(8'h42);
    done_frame("t7_after", 64'h42, 4'd1, 1'b0, 16'd0);
    take();
    @(negedge clk);
    bus.in_data = 8'h00;
    bus.in_rdy  = 1'b1;
    repeat (65536 + 3) @(posedge clk);
    @(negedge clk);
    bus.in_rdy = 1'b0;
    chk("t8_saturate", 64'(bus.err_count), 64'hFFFF);
    chk("t8_no_frame", 64'(bus.rdy_frame), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
